udp_writer: RTL and testbench
=============================

UDP_WRITER -- requirements
Module: udp_writer

Interface
REQ-001 SHALL have parameter CAPACITY, default 4: payload bytes per message, legal range 1..64.
REQ-002 SHALL have parameter TIMEOUT, default 125_000: idle-cycle limit in ARM/SEND, used only when the timeout feature is compiled in.
REQ-003 SHALL have port clk, input, 1: single clock, the rgmii_clk domain.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port load, input, 1: one-cycle request to queue i_data.
REQ-006 SHALL have port i_data, input, CAPACITY*8: message, byte 0 in the MSBs.
REQ-007 SHALL have port trig, output, 1: one-cycle start pulse to the UDP transmitter.
REQ-008 SHALL have port read_en, input, 1: byte request from the UDP transmitter.
REQ-009 SHALL have port valid, output, 1: o_data is valid this cycle.
REQ-010 SHALL have port o_data, output, 8: payload byte.
REQ-011 SHALL have port data_len, output, 16: constant CAPACITY.
REQ-012 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-013 SHALL have port done, output, 1: one-cycle pulse after the last byte.
REQ-014 SHALL have port ovr_err, output, 1: sticky, a message was dropped.
REQ-015 SHALL have port und_err, output, 1: sticky, read_en arrived with no byte to send.

Function
REQ-016 SHALL implement states IDLE, ARM, SEND and DONE.
REQ-017 In IDLE, load or a pending message SHALL copy the message into the shift register, pulse trig the next cycle and enter ARM; load takes effect with 1-cycle latency.
REQ-018 In ARM/SEND, each cycle with read_en=1 SHALL, one cycle later, drive valid=1 and o_data = the next byte, MSB-first order; the first read_en moves the block to SEND.
REQ-019 When read_en=0 in SEND, the block SHALL pause: valid=0 and the byte index is held.
REQ-020 After byte CAPACITY-1 has been presented, the block SHALL enter DONE, pulse done for one cycle, then return to IDLE.
REQ-021 A pending message SHALL start on the cycle after DONE, with no IDLE dwell cycle.
REQ-022 A load while busy SHALL be stored in a one-deep pending register.
REQ-023 A load while pending is full SHALL be dropped and SHALL set ovr_err; the pending contents are kept.
REQ-024 A load in the same cycle as pending is consumed SHALL be accepted into pending without error.
REQ-025 read_en in IDLE or DONE SHALL set und_err, and valid SHALL stay 0.
REQ-026 The byte index SHALL be $clog2(CAPACITY)+1 bits wide and SHALL never wrap; data_len SHALL be zero-extended.
REQ-027 When CAPACITY=1, a single read_en SHALL complete the message.

Reset
REQ-028 When rst=1 at a clk edge, the block SHALL go to IDLE and clear pending, trig, valid, o_data (to 0x00), done, ovr_err and und_err.
REQ-029 Reset asserted mid-message SHALL abort the transfer with no done pulse; valid SHALL be 0 on the cycle after the reset edge.
REQ-030 The sticky errors SHALL clear only on rst.

Configuration
REQ-031 With macro UDP_WRITER_TIMEOUT_EN defined, TIMEOUT consecutive cycles without read_en in ARM/SEND SHALL abort to IDLE, set und_err and suppress done.
REQ-032 With UDP_WRITER_TIMEOUT_EN undefined, the block SHALL wait in ARM/SEND indefinitely, and no timeout counter SHALL be synthesised.

Verification
REQ-033 Bench SHALL cover basic send: CAPACITY=4, load i_data=0xDEADBEEF, read_en high 4 cycles -> trig pulse, then valid for 4 cycles with DE, AD, BE, EF, then one done pulse, then busy=0.
REQ-034 Bench SHALL cover pause: read_en pattern 1,0,0,1,1,1 -> bytes DE, (gap), AD, BE, EF, with no repeats or skips.
REQ-035 Bench SHALL cover queue: load A, then load B mid-send -> A completes, trig for B on the cycle after done, B sent; a third load during B before pending frees -> ovr_err=1 and C is never sent.
REQ-036 Bench SHALL cover underrun: read_en for 5 cycles with CAPACITY=4 -> 4 valid bytes, und_err=1 on the 5th, o_data unchanged.
REQ-037 Bench SHALL cover reset mid-message: rst after 2 bytes -> valid=0 and busy=0 next cycle, no done, errors=0; a new load sends the full message from byte 0.
REQ-038 Bench SHALL cover timeout with UDP_WRITER_TIMEOUT_EN and TIMEOUT=16: load with no read_en -> busy drops at trig+16 cycles, und_err=1, no done.

Source files
------------

// File: rtl/udp_writer_if.sv
// Handshake and status bundle between a message source, udp_writer and the UDP transmitter.
// slave: the writer's view. master: the view of whatever drives the writer.
interface udp_writer_if #(
  parameter int CAPACITY = 4
);
  logic                  load;
  logic [CAPACITY*8-1:0] i_data;
  logic                  trig;
  logic                  read_en;
  logic                  valid;
  logic [7:0]            o_data;
  logic [15:0]           data_len;
  logic                  busy;
  logic                  done;
  logic                  ovr_err;
  logic                  und_err;

  modport slave (
    input  load, i_data, read_en,
    output trig, valid, o_data, data_len, busy, done, ovr_err, und_err
  );

  modport master (
    output load, i_data, read_en,
    input  trig, valid, o_data, data_len, busy, done, ovr_err, und_err
  );
endinterface

// File: rtl/udp_writer.sv
// Holds one CAPACITY-byte message plus a one-deep pending slot and streams it MSB-first on read_en.
// Define UDP_WRITER_TIMEOUT_EN to abort after TIMEOUT idle cycles in ARM/SEND.
module udp_writer #(
  parameter int CAPACITY = 4,
  parameter int TIMEOUT  = 125_000
) (
  input  logic        clk,
  input  logic        rst,
  udp_writer_if.slave bus
);
  localparam int MSG_W = CAPACITY * 8;
  localparam int IDX_W = $clog2(CAPACITY) + 1;
  localparam logic [IDX_W-1:0] IDX_END = IDX_W'(CAPACITY);

  if (CAPACITY < 1 || CAPACITY > 64) begin : g_bad_capacity
    $error("udp_writer: CAPACITY must be in 1..64");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("udp_writer: TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, ARM, SEND, DONE} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [MSG_W-1:0]   r_shift;
  logic [MSG_W-1:0]   r_pend_data;
  logic               r_pend_valid;
  logic [IDX_W-1:0]   r_idx;
  logic               r_trig;
  logic               r_valid;
  logic [7:0]         r_o_data;
  logic               r_ovr_err;
  logic               r_und_err;

  logic w_start;
  logic w_active;
  logic w_exhausted;
  logic w_issue;
  logic w_underrun;
  logic w_timeout;
  logic w_pend_take;
  logic w_pend_load;
  logic w_overrun;

  assign w_active    = (r_state == ARM) || (r_state == SEND);
  assign w_exhausted = (r_idx == IDX_END);
  assign w_issue     = w_active && bus.read_en && !w_exhausted;
  assign w_underrun  = bus.read_en && !w_issue;

  // A load goes straight to the shift register only when IDLE has nothing pending;
  // otherwise it targets the pending slot, which may be freed in the same cycle.
  assign w_pend_take = w_start && r_pend_valid;
  assign w_pend_load = bus.load && !(w_start && !r_pend_valid) && (!r_pend_valid || w_pend_take);
  assign w_overrun   = bus.load && r_pend_valid && !w_pend_take;

`ifdef UDP_WRITER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] r_idle_cnt;

  always_ff @(posedge clk) begin
    if (rst || !w_active || bus.read_en) r_idle_cnt <= '0;
    else                                 r_idle_cnt <= r_idle_cnt + 1'b1;
  end

  assign w_timeout = w_active && !bus.read_en && !w_exhausted &&
                     (r_idle_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.load || r_pend_valid) begin
          w_state_next = ARM;
          w_start      = 1'b1;
        end
      end
      ARM, SEND: begin
        if (w_exhausted)      w_state_next = DONE;
        else if (w_timeout)   w_state_next = IDLE;
        else if (bus.read_en) w_state_next = SEND;
      end
      DONE: begin
        w_state_next = IDLE;
        if (r_pend_valid) begin
          w_state_next = ARM;
          w_start      = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_pend_valid <= 1'b0;
      r_idx        <= '0;
      r_trig       <= 1'b0;
      r_valid      <= 1'b0;
      r_o_data     <= 8'h00;
      r_ovr_err    <= 1'b0;
      r_und_err    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_trig  <= w_start;
      r_valid <= w_issue;

      if (w_start)      r_idx <= '0;
      else if (w_issue) r_idx <= r_idx + 1'b1;

      if (w_issue) r_o_data <= r_shift[MSG_W-1 -: 8];

      if (w_pend_load)      r_pend_valid <= 1'b1;
      else if (w_pend_take) r_pend_valid <= 1'b0;

      if (w_overrun)               r_ovr_err <= 1'b1;
      if (w_underrun || w_timeout) r_und_err <= 1'b1;
    end
  end

  // NOTE: payload storage has no reset; it is only observed after being loaded behind a valid flag.
  always_ff @(posedge clk) begin
    if (w_start)      r_shift <= r_pend_valid ? r_pend_data : bus.i_data;
    else if (w_issue) r_shift <= r_shift << 8;

    if (w_pend_load) r_pend_data <= bus.i_data;
  end

  assign bus.trig     = r_trig;
  assign bus.valid    = r_valid;
  assign bus.o_data   = r_o_data;
  assign bus.data_len = 16'(CAPACITY);
  assign bus.busy     = (r_state != IDLE);
  assign bus.done     = (r_state == DONE);
  assign bus.ovr_err  = r_ovr_err;
  assign bus.und_err  = r_und_err;
endmodule

// File: tb/tb_udp_writer.sv
// Directed bench for udp_writer: every emitted byte is popped from a scoreboard filled at load time,
// control pulses and sticky errors are checked at fixed cycle offsets.
module tb_udp_writer;
  localparam int CAPACITY = 4;
  localparam int TIMEOUT  = 16;
  localparam logic [5:0] PAUSE_PAT = 6'b111001;

  logic       clk = 1'b0;
  logic       rst;
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] sb_q[$];
  logic       saw_done;

  udp_writer_if #(.CAPACITY(CAPACITY)) bus ();

  udp_writer #(.CAPACITY(CAPACITY), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_msg(input logic [CAPACITY*8-1:0] msg);
    for (int i = CAPACITY - 1; i >= 0; i--) sb_q.push_back(msg[i*8 +: 8]);
  endtask

  // One-cycle load pulse; returns on the following negedge, where trig is expected.
  task automatic load_msg(input logic [CAPACITY*8-1:0] msg, input bit expect_sent);
    bus.i_data = msg;
    bus.load   = 1'b1;
    if (expect_sent) push_msg(msg);
    tick();
    bus.load = 1'b0;
  endtask

  // Byte scoreboard: every valid cycle must match the oldest outstanding byte.
  always @(negedge clk) begin
    if (bus.valid === 1'b1) begin
      check("byte_outstanding", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) check("o_data", 32'(bus.o_data), 32'(sb_q.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst         = 1'b1;
    bus.load    = 1'b0;
    bus.read_en = 1'b0;
    bus.i_data  = '0;
    saw_done    = 1'b0;
    tick(3);
    rst = 1'b0;

    check("rst_busy",     32'(bus.busy),     32'd0);
    check("rst_valid",    32'(bus.valid),    32'd0);
    check("rst_o_data",   32'(bus.o_data),   32'h00);
    check("rst_trig",     32'(bus.trig),     32'd0);
    check("rst_done",     32'(bus.done),     32'd0);
    check("rst_ovr_err",  32'(bus.ovr_err),  32'd0);
    check("rst_und_err",  32'(bus.und_err),  32'd0);
    check("data_len",     32'(bus.data_len), 32'd4);

    // Basic send.
    load_msg(32'hDEADBEEF, 1'b1);
    check("basic_trig",        32'(bus.trig),  32'd1);
    check("basic_busy",        32'(bus.busy),  32'd1);
    check("basic_valid_early", 32'(bus.valid), 32'd0);
    bus.read_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("basic_valid", 32'(bus.valid), 32'd1);
      if (i == 0) check("basic_trig_pulse", 32'(bus.trig), 32'd0);
    end
    bus.read_en = 1'b0;
    tick();
    check("basic_done",       32'(bus.done),  32'd1);
    check("basic_valid_done", 32'(bus.valid), 32'd0);
    tick();
    check("basic_done_pulse", 32'(bus.done),   32'd0);
    check("basic_busy_end",   32'(bus.busy),   32'd0);
    check("basic_sb_empty",   32'(sb_q.size()), 32'd0);

    // Pause: read_en 1,0,0,1,1,1.
    load_msg(32'hDEADBEEF, 1'b1);
    check("pause_trig", 32'(bus.trig), 32'd1);
    for (int i = 0; i < 6; i++) begin
      bus.read_en = PAUSE_PAT[i];
      tick();
      check("pause_valid", 32'(bus.valid), 32'(PAUSE_PAT[i]));
    end
    bus.read_en = 1'b0;
    tick();
    check("pause_done", 32'(bus.done), 32'd1);
    tick();
    check("pause_busy_end", 32'(bus.busy),   32'd0);
    check("pause_sb_empty", 32'(sb_q.size()), 32'd0);

    // Queue: A sending, B pending, C dropped.
    load_msg(32'h11223344, 1'b1);
    check("queue_trig_a", 32'(bus.trig), 32'd1);
    bus.read_en = 1'b1;
    tick();
    bus.i_data = 32'h55667788;
    bus.load   = 1'b1;
    push_msg(32'h55667788);
    tick();
    check("queue_ovr_after_b", 32'(bus.ovr_err), 32'd0);
    bus.i_data = 32'h99AABBCC;
    tick();
    bus.load = 1'b0;
    check("queue_ovr_after_c", 32'(bus.ovr_err), 32'd1);
    tick();
    bus.read_en = 1'b0;
    tick();
    check("queue_done_a",    32'(bus.done), 32'd1);
    check("queue_no_trig_a", 32'(bus.trig), 32'd0);
    tick();
    check("queue_trig_b",    32'(bus.trig), 32'd1);
    check("queue_done_gone", 32'(bus.done), 32'd0);
    check("queue_busy_b",    32'(bus.busy), 32'd1);
    bus.read_en = 1'b1;
    tick(4);
    bus.read_en = 1'b0;
    tick();
    check("queue_done_b", 32'(bus.done), 32'd1);
    tick(6);
    check("queue_c_not_sent", 32'(bus.busy),    32'd0);
    check("queue_ovr_sticky", 32'(bus.ovr_err), 32'd1);
    check("queue_sb_empty",   32'(sb_q.size()), 32'd0);

    // Underrun: five read_en for four bytes.
    check("und_clear_before", 32'(bus.und_err), 32'd0);
    load_msg(32'hDEADBEEF, 1'b1);
    check("und_trig", 32'(bus.trig), 32'd1);
    bus.read_en = 1'b1;
    tick(5);
    bus.read_en = 1'b0;
    check("und_err_set",   32'(bus.und_err), 32'd1);
    check("und_valid",     32'(bus.valid),   32'd0);
    check("und_o_data",    32'(bus.o_data),  32'hEF);
    check("und_done",      32'(bus.done),    32'd1);
    tick();
    check("und_busy_end", 32'(bus.busy), 32'd0);

    // Reset mid-message after two bytes.
    load_msg(32'h0123A5C3, 1'b1);
    check("rstmid_trig", 32'(bus.trig), 32'd1);
    bus.read_en = 1'b1;
    tick(2);
    bus.read_en = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid_valid",   32'(bus.valid),   32'd0);
    check("rstmid_busy",    32'(bus.busy),    32'd0);
    check("rstmid_done",    32'(bus.done),    32'd0);
    check("rstmid_ovr",     32'(bus.ovr_err), 32'd0);
    check("rstmid_und",     32'(bus.und_err), 32'd0);
    check("rstmid_unsent",  32'(sb_q.size()), 32'd2);
    sb_q.delete();
    tick(2);
    check("rstmid_no_done", 32'(bus.done), 32'd0);
    load_msg(32'hCAFEF00D, 1'b1);
    check("rstmid_trig_new", 32'(bus.trig), 32'd1);
    bus.read_en = 1'b1;
    tick(4);
    bus.read_en = 1'b0;
    tick();
    check("rstmid_done_new", 32'(bus.done), 32'd1);
    tick();
    check("rstmid_busy_new", 32'(bus.busy),   32'd0);
    check("rstmid_sb_empty", 32'(sb_q.size()), 32'd0);

    // read_en while IDLE.
    bus.read_en = 1'b1;
    tick();
    bus.read_en = 1'b0;
    check("idle_read_und",   32'(bus.und_err), 32'd1);
    check("idle_read_valid", 32'(bus.valid),   32'd0);
    check("idle_read_busy",  32'(bus.busy),    32'd0);

`ifdef UDP_WRITER_TIMEOUT_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("to_und_clear", 32'(bus.und_err), 32'd0);
    load_msg(32'h5A5A5A5A, 1'b0);
    check("to_trig", 32'(bus.trig), 32'd1);
    for (int k = 1; k <= TIMEOUT; k++) begin
      tick();
      if (bus.done === 1'b1) saw_done = 1'b1;
      if (k == TIMEOUT - 1) check("to_busy_before", 32'(bus.busy), 32'd1);
    end
    check("to_busy_after", 32'(bus.busy),    32'd0);
    check("to_und_set",    32'(bus.und_err), 32'd1);
    check("to_no_done",    32'(saw_done),    32'd0);
`else
    load_msg(32'h5A5A5A5A, 1'b0);
    check("wait_trig", 32'(bus.trig), 32'd1);
    tick(40);
    check("wait_busy",  32'(bus.busy),  32'd1);
    check("wait_valid", 32'(bus.valid), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("wait_rst_busy", 32'(bus.busy), 32'd0);
`endif

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
